// File: rtl/tv_timing_gen.sv
// ---------------------------------------------------------------------------
// tv_timing_gen
//
// Composite-TV (PAL) timing generator. A clock-position counter (tv_pos)
// spans one full line; a half-line counter (tv_halfline) spans one field; a
// 3-bit field counter follows field wraps. From those it derives composite
// sync (broad / equalising / line pulses), blanking, the colourburst window,
// the burst-phase select and a vertical strobe for the OSD. The generator can
// be forced back to the top of a field by a falling edge on ext_vs.
//
// Ports
//   clk24        in   system clock
//   rst_n        in   asynchronous active-low reset
//   ce           in   clock enable, all state holds while low
//   interlace    in   1: FIELD_HL+1 half-lines per field, 0: FIELD_HL
//   field_alt_en in   alternate burst phase from field to field
//   ext_lock     in   allow resync on an ext_vs falling edge
//   ext_vs       in   external vertical sync
//   tv_sync      out  composite sync, active low
//   tv_blank     out  blanking, including the whole field-sync zone
//   tv_burst     out  colourburst window
//   phase_sel    out  burst phase select
//   tv_halfline  out  half-line within field
//   tv_pos       out  clock position within full line
//   field_ctr    out  field counter
//   line_start   out  strobe when tv_pos wraps to 0
//   field_start  out  strobe when tv_halfline becomes 0
//   osd_vsync_n  out  low for the whole of half-line OSD_HL
// ---------------------------------------------------------------------------
module tv_timing_gen #(
    parameter int LINE_CLKS   = 1536,
    parameter int HSYNC_CLKS  = 114,
    parameter int EQ_CLKS     = 56,
    parameter int BROAD_CLKS  = 655,
    parameter int BURST_START = 139,
    parameter int BURST_END   = 212,
    parameter int BLANK_END   = 249,
    parameter int BLANK_START = 1497,
    parameter int BROAD_HL    = 5,
    parameter int EQ_POST_HL  = 10,
    parameter int EQ_PRE_HL   = 618,
    parameter int FIELD_HL    = 624,
    parameter int OSD_HL      = 275,
    parameter int HL_W        = 11
) (
    input  logic            clk24,
    input  logic            rst_n,
    input  logic            ce,
    input  logic            interlace,
    input  logic            field_alt_en,
    input  logic            ext_lock,
    input  logic            ext_vs,
    output logic            tv_sync,
    output logic            tv_blank,
    output logic            tv_burst,
    output logic            phase_sel,
    output logic [HL_W-1:0] tv_halfline,
    output logic [10:0]     tv_pos,
    output logic [2:0]      field_ctr,
    output logic            line_start,
    output logic            field_start,
    output logic            osd_vsync_n
);

    localparam int HALF = LINE_CLKS / 2;

    localparam logic [10:0] POS_LAST    = 11'(LINE_CLKS - 1);
    localparam logic [10:0] POS_HALF_M1 = 11'(HALF - 1);
    localparam logic [10:0] POS_HALF    = 11'(HALF);
    localparam logic [10:0] P_HSYNC     = 11'(HSYNC_CLKS);
    localparam logic [10:0] P_EQ        = 11'(EQ_CLKS);
    localparam logic [10:0] P_BROAD     = 11'(BROAD_CLKS);
    localparam logic [10:0] P_BST_START = 11'(BURST_START);
    localparam logic [10:0] P_BST_END   = 11'(BURST_END);
    localparam logic [10:0] P_BLK_END   = 11'(BLANK_END);
    localparam logic [10:0] P_BLK_START = 11'(BLANK_START);

    localparam logic [HL_W-1:0] HL_BROAD    = HL_W'(BROAD_HL);
    localparam logic [HL_W-1:0] HL_EQ_POST  = HL_W'(EQ_POST_HL);
    localparam logic [HL_W-1:0] HL_EQ_PRE   = HL_W'(EQ_PRE_HL);
    localparam logic [HL_W-1:0] HL_OSD      = HL_W'(OSD_HL);
    localparam logic [HL_W-1:0] HL_FIELD    = HL_W'(FIELD_HL);
    localparam logic [HL_W-1:0] HL_FIELD_M1 = HL_W'(FIELD_HL - 1);

    // Elaboration-time guard against an inconsistent timing set.
    if (!((LINE_CLKS % 2 == 0) && (LINE_CLKS <= 2048) &&
          (HSYNC_CLKS < BURST_START) && (BURST_START <= BURST_END) &&
          (BURST_END < BLANK_END) && (BLANK_END < BLANK_START) &&
          (BLANK_START < LINE_CLKS) && (EQ_CLKS < HSYNC_CLKS) &&
          (BROAD_CLKS < HALF) && (BROAD_HL < EQ_POST_HL) &&
          (EQ_POST_HL < EQ_PRE_HL) && (EQ_PRE_HL < FIELD_HL) &&
          (HL_W >= 2) && (FIELD_HL < (1 << HL_W)))) begin : g_bad_params
        $error("tv_timing_gen: inconsistent timing parameters");
    end

    logic            vs_q;
    logic            ext_fall;
    logic            hl_step;
    logic            hl_last;
    logic [HL_W-1:0] fl_last;
    logic [10:0]     pos_nx;
    logic [10:0]     hpos_nx;
    logic [HL_W-1:0] hl_nx;
    logic [2:0]      fc_nx;
    logic            ls_nx;
    logic            fs_nx;
    logic            broad_zone;
    logic            eq_zone;
    logic            field_zone;
    logic            sync_nx;
    logic            blank_nx;
    logic            burst_nx;
    logic            osd_nx;

    // Field length follows the live interlace input; a half-line count that
    // already exceeds the new last value wraps on the next increment.
    assign fl_last  = interlace ? HL_FIELD : HL_FIELD_M1;
    assign ext_fall = ext_lock & vs_q & ~ext_vs;
    assign hl_step  = (tv_pos == POS_HALF_M1) || (tv_pos == POS_LAST);
    assign hl_last  = (tv_halfline >= fl_last);

    // Next counter values; outputs are decoded from these so that the
    // registered outputs match the counters of the same edge.
    always_comb begin
        pos_nx = (tv_pos == POS_LAST) ? 11'd0 : tv_pos + 11'd1;
        ls_nx  = (tv_pos == POS_LAST);
        fs_nx  = hl_step & hl_last;
        hl_nx  = tv_halfline;
        if (hl_step) begin
            hl_nx = hl_last ? '0 : tv_halfline + 1'b1;
        end
        fc_nx = field_ctr + {2'b00, fs_nx};
        // Resync overrides a coincident natural wrap; the field counter
        // still advances only once.
        if (ext_fall) begin
            pos_nx = 11'd0;
            hl_nx  = '0;
            fc_nx  = field_ctr + 3'd1;
            ls_nx  = 1'b1;
            fs_nx  = 1'b1;
        end
    end

    always_comb begin
        hpos_nx    = (pos_nx < POS_HALF) ? pos_nx : pos_nx - POS_HALF;
        broad_zone = (hl_nx < HL_BROAD);
        eq_zone    = ~broad_zone && ((hl_nx < HL_EQ_POST) || (hl_nx >= HL_EQ_PRE));
        field_zone = broad_zone | eq_zone;
        if (broad_zone) begin
            sync_nx = ~(hpos_nx < P_BROAD);
        end else if (eq_zone) begin
            sync_nx = ~(hpos_nx < P_EQ);
        end else begin
            // Normal line sync is once per full line, hence pos not hpos.
            sync_nx = ~(pos_nx < P_HSYNC);
        end
        blank_nx = field_zone || (pos_nx < P_BLK_END) || (pos_nx >= P_BLK_START);
        burst_nx = ~field_zone && (pos_nx >= P_BST_START) && (pos_nx <= P_BST_END);
        osd_nx   = ~(hl_nx == HL_OSD);
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            tv_pos      <= 11'd0;
            tv_halfline <= '0;
            field_ctr   <= 3'd0;
            vs_q        <= 1'b0;
            tv_sync     <= 1'b1;
            tv_blank    <= 1'b1;
            tv_burst    <= 1'b0;
            line_start  <= 1'b0;
            field_start <= 1'b0;
            osd_vsync_n <= 1'b1;
        end else if (ce) begin
            tv_pos      <= pos_nx;
            tv_halfline <= hl_nx;
            field_ctr   <= fc_nx;
            vs_q        <= ext_vs;
            tv_sync     <= sync_nx;
            tv_blank    <= blank_nx;
            tv_burst    <= burst_nx;
            line_start  <= ls_nx;
            field_start <= fs_nx;
            osd_vsync_n <= osd_nx;
        end
    end

    // Burst phase flips every second half-line, and optionally every field.
    assign phase_sel = tv_halfline[1] ^ (field_alt_en & field_ctr[0]);

endmodule

// File: tb/tb_tv_timing_gen.sv
// Bench for tv_timing_gen using a scaled-down timing set so whole fields fit
// in a short run: line = 96 clocks (half-line 48), field = 44 half-lines.
module tb_tv_timing_gen;

    localparam int HL_W = 11;

    logic            clk24 = 1'b0;
    logic            rst_n, ce, interlace, field_alt_en, ext_lock, ext_vs;
    logic            tv_sync, tv_blank, tv_burst, phase_sel;
    logic [HL_W-1:0] tv_halfline;
    logic [10:0]     tv_pos;
    logic [2:0]      field_ctr;
    logic            line_start, field_start, osd_vsync_n;

    int n;
    int checks;
    int errors;

    always #5 clk24 = ~clk24;

    tv_timing_gen #(
        .LINE_CLKS(96), .HSYNC_CLKS(8), .EQ_CLKS(4), .BROAD_CLKS(40),
        .BURST_START(10), .BURST_END(14), .BLANK_END(18), .BLANK_START(90),
        .BROAD_HL(5), .EQ_POST_HL(10), .EQ_PRE_HL(40), .FIELD_HL(44),
        .OSD_HL(20), .HL_W(HL_W)
    ) dut (
        .clk24(clk24), .rst_n(rst_n), .ce(ce), .interlace(interlace),
        .field_alt_en(field_alt_en), .ext_lock(ext_lock), .ext_vs(ext_vs),
        .tv_sync(tv_sync), .tv_blank(tv_blank), .tv_burst(tv_burst),
        .phase_sel(phase_sel), .tv_halfline(tv_halfline), .tv_pos(tv_pos),
        .field_ctr(field_ctr), .line_start(line_start),
        .field_start(field_start), .osd_vsync_n(osd_vsync_n)
    );

    typedef struct {
        int n;
        int pos;
        int hl;
        int sync;
        int blank;
        int burst;
        int osd;
        int ls;
        int fs;
        int fc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk24);
        #1;
        if (ce) n++;
    endtask

    task automatic run_to(input int t);
        while (n < t) tick();
    endtask

    task automatic do_reset();
        @(posedge clk24);
        #2;
        rst_n = 1'b0;
        @(posedge clk24);
        #2;
        rst_n = 1'b1;
        n = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pos"},   int'(tv_pos), 0);
        chk({tag, "_hl"},    int'(tv_halfline), 0);
        chk({tag, "_fc"},    int'(field_ctr), 0);
        chk({tag, "_sync"},  int'(tv_sync), 1);
        chk({tag, "_blank"}, int'(tv_blank), 1);
        chk({tag, "_burst"}, int'(tv_burst), 0);
        chk({tag, "_osd"},   int'(osd_vsync_n), 1);
        chk({tag, "_ls"},    int'(line_start), 0);
        chk({tag, "_fs"},    int'(field_start), 0);
    endtask

    initial begin
        int osd_lows;
        string t;
        checks = 0;
        errors = 0;
        n = 0;
        rst_n = 1'b0;
        ce = 1'b1;
        interlace = 1'b0;
        field_alt_en = 1'b0;
        ext_lock = 1'b0;
        ext_vs = 1'b0;

        // n, pos, hl, sync, blank, burst, osd, line_start, field_start, fc
        tbl.push_back('{1,    1,  0, 0, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{39,   39, 0, 0, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{40,   40, 0, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{48,   48, 1, 0, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{243,  51, 5, 0, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{279,  87, 5, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{435,  51, 9, 0, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{436,  52, 9, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{480,  0, 10, 0, 1, 0, 1, 1, 0, 0});
        tbl.push_back('{487,  7, 10, 0, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{488,  8, 10, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{490, 10, 10, 1, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{494, 14, 10, 1, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{495, 15, 10, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{497, 17, 10, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{498, 18, 10, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{530, 50, 11, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{569, 89, 11, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{570, 90, 11, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{960,  0, 20, 0, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{1007, 47, 20, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1008, 48, 21, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1920, 0, 40, 0, 1, 0, 1, 1, 0, 0});
        tbl.push_back('{1924, 4, 40, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{1932, 12, 40, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{2111, 95, 43, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{2112, 0,  0, 0, 1, 0, 1, 1, 1, 1});
        tbl.push_back('{2113, 1,  0, 0, 1, 0, 1, 0, 0, 1});

        // Reset state while rst_n is held low.
        #12;
        chk_reset_vals("rst");
        @(posedge clk24);
        #2;
        rst_n = 1'b1;
        n = 0;

        // Free-running progressive field.
        foreach (tbl[i]) begin
            run_to(tbl[i].n);
            t = $sformatf("n%0d", tbl[i].n);
            chk({t, "_pos"},   int'(tv_pos), tbl[i].pos);
            chk({t, "_hl"},    int'(tv_halfline), tbl[i].hl);
            chk({t, "_sync"},  int'(tv_sync), tbl[i].sync);
            chk({t, "_blank"}, int'(tv_blank), tbl[i].blank);
            chk({t, "_burst"}, int'(tv_burst), tbl[i].burst);
            chk({t, "_osd"},   int'(osd_vsync_n), tbl[i].osd);
            chk({t, "_ls"},    int'(line_start), tbl[i].ls);
            chk({t, "_fs"},    int'(field_start), tbl[i].fs);
            chk({t, "_fc"},    int'(field_ctr), tbl[i].fc);
            chk({t, "_phase"}, int'(phase_sel), (tbl[i].hl >> 1) & 1);
        end

        // Interlaced fields of 45 half-lines with per-field phase alternation.
        interlace = 1'b1;
        field_alt_en = 1'b1;
        do_reset();
        osd_lows = 0;
        while (n < 2160) begin
            tick();
            if (!osd_vsync_n) osd_lows++;
            if (n == 100) chk("il_phase_f0", int'(phase_sel), 1);
        end
        chk("il_osd_len", osd_lows, 48);
        chk("il_f1_pos", int'(tv_pos), 48);
        chk("il_f1_hl", int'(tv_halfline), 0);
        chk("il_f1_fs", int'(field_start), 1);
        chk("il_f1_ls", int'(line_start), 0);
        chk("il_f1_fc", int'(field_ctr), 1);
        run_to(2256);
        chk("il_f1_hl2", int'(tv_halfline), 2);
        chk("il_phase_f1", int'(phase_sel), 0);
        run_to(4320);
        chk("il_f2_pos", int'(tv_pos), 0);
        chk("il_f2_hl", int'(tv_halfline), 0);
        chk("il_f2_fc", int'(field_ctr), 2);
        chk("il_f2_fs", int'(field_start), 1);

        // External resync mid-field, coincident with a natural wrap, and ignored.
        interlace = 1'b0;
        field_alt_en = 1'b0;
        ext_lock = 1'b1;
        ext_vs = 1'b1;
        do_reset();
        run_to(1510);
        chk("ext_pre_pos", int'(tv_pos), 70);
        chk("ext_pre_hl", int'(tv_halfline), 31);
        ext_vs = 1'b0;
        tick();
        chk("ext_pos", int'(tv_pos), 0);
        chk("ext_hl", int'(tv_halfline), 0);
        chk("ext_fc", int'(field_ctr), 1);
        chk("ext_fs", int'(field_start), 1);
        chk("ext_ls", int'(line_start), 1);
        ext_vs = 1'b1;
        tick();
        chk("ext_next_pos", int'(tv_pos), 1);
        chk("ext_next_fs", int'(field_start), 0);
        chk("ext_next_fc", int'(field_ctr), 1);
        run_to(3622);
        ext_vs = 1'b0;
        tick();
        chk("ext_coinc_pos", int'(tv_pos), 0);
        chk("ext_coinc_hl", int'(tv_halfline), 0);
        chk("ext_coinc_fc", int'(field_ctr), 2);
        chk("ext_coinc_fs", int'(field_start), 1);
        ext_lock = 1'b0;
        ext_vs = 1'b1;
        run_to(3822);
        ext_vs = 1'b0;
        tick();
        chk("ext_off_pos", int'(tv_pos), 8);
        chk("ext_off_hl", int'(tv_halfline), 4);
        chk("ext_off_fc", int'(field_ctr), 2);
        chk("ext_off_fs", int'(field_start), 0);

        // Clock enable active one clock in two.
        do_reset();
        for (int i = 1; i <= 192; i++) begin
            ce = (i % 2 == 0);
            @(posedge clk24);
            #1;
            if (i == 96) begin
                chk("ce_mid_pos", int'(tv_pos), 48);
                chk("ce_mid_hl", int'(tv_halfline), 1);
            end
            if (i == 97) chk("ce_hold_pos", int'(tv_pos), 48);
        end
        chk("ce_wrap_pos", int'(tv_pos), 0);
        chk("ce_wrap_hl", int'(tv_halfline), 2);
        chk("ce_wrap_ls", int'(line_start), 1);
        ce = 1'b0;
        @(posedge clk24);
        #1;
        chk("ce_off_pos", int'(tv_pos), 0);
        chk("ce_off_ls", int'(line_start), 1);
        ce = 1'b1;
        @(posedge clk24);
        #1;
        chk("ce_on_pos", int'(tv_pos), 1);
        chk("ce_on_ls", int'(line_start), 0);

        // Asynchronous reset in the middle of the OSD half-line.
        do_reset();
        run_to(960);
        chk("mid_pre_sync", int'(tv_sync), 0);
        chk("mid_pre_osd", int'(osd_vsync_n), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid");
        @(posedge clk24);
        #2;
        rst_n = 1'b1;
        n = 0;
        tick();
        chk("rel_pos", int'(tv_pos), 1);
        chk("rel_hl", int'(tv_halfline), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tv_timing_gen.md
Name: tv_timing_gen

Overview:
- Parametrised composite-TV timing generator for the PAL/TV output path.
- Replaces the fixed half-line/pixel counters, sync-window logic and field counter in the video subsystem.
- Produces composite sync, blanking, colourburst window, burst-phase select, field tracking and the OSD vertical strobe.
- Supports progressive (624 half-lines/field) and true interlaced (625 half-lines/field) timing, plus optional lock to the VGA refresher's vertical sync.

Parameters:
- LINE_CLKS, 1536, clocks per full line; even; half-line HALF = LINE_CLKS/2.
- HSYNC_CLKS, 114, normal line-sync pulse width.
- EQ_CLKS, 56, equalising pulse width.
- BROAD_CLKS, 655, broad-pulse low width within a half-line.
- BURST_START, 139, first clock of burst window (inclusive).
- BURST_END, 212, last clock of burst window (inclusive).
- BLANK_END, 249, blank while pos < BLANK_END.
- BLANK_START, 1497, blank while pos >= BLANK_START.
- BROAD_HL, 5, broad pulses on half-lines 0..BROAD_HL-1.
- EQ_POST_HL, 10, equalising pulses on half-lines BROAD_HL..EQ_POST_HL-1.
- EQ_PRE_HL, 618, equalising pulses on half-lines >= EQ_PRE_HL.
- FIELD_HL, 624, half-lines per progressive field.
- OSD_HL, 275, half-line carrying the osd_vsync_n strobe.
- HL_W, 11, half-line counter width.

Ports:
- clk24  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; all state holds when low
- interlace  in  1  1 = 625 half-line fields, 0 = FIELD_HL
- field_alt_en  in  1  enables per-field burst-phase alternation
- ext_lock  in  1  enables resync on ext_vs falling edge
- ext_vs  in  1  external vertical sync (refresher tvvs)
- tv_sync  out  1  composite sync, active low
- tv_blank  out  1  blanking (incl. whole field-sync zone)
- tv_burst  out  1  colourburst window
- phase_sel  out  1  halfline[1] ^ (field_alt_en & field_ctr[0])
- tv_halfline  out  HL_W  current half-line within field
- tv_pos  out  11  clock position within full line, 0..LINE_CLKS-1
- field_ctr  out  3  field counter
- line_start  out  1  one-cycle strobe when tv_pos wraps to 0
- field_start  out  1  one-cycle strobe when tv_halfline becomes 0
- osd_vsync_n  out  1  low for the whole of half-line OSD_HL

Behaviour:
- Reset values:
  - pos = 0, halfline = 0, field_ctr = 0.
  - tv_sync = 1, tv_blank = 1, tv_burst = 0.
  - line_start = 0, field_start = 0, osd_vsync_n = 1.
  - ext_vs sampling register = 0.
- All outputs are registered; they update on the clk24 edge with ce = 1 and reflect counter values of that same edge.
- pos advances by 1 per ce and wraps LINE_CLKS-1 -> 0 (line_start = 1 on that edge).
- hpos = pos when pos < HALF, else pos - HALF.
- halfline increments when pos reaches HALF-1 or LINE_CLKS-1.
  - Field length FL = interlace ? FIELD_HL+1 : FIELD_HL.
  - halfline wraps FL-1 -> 0 with field_start = 1 and field_ctr + 1 (3-bit wrap 7 -> 0).
  - In interlace mode, odd fields therefore begin mid-line; pos is never reset by a field wrap.
- Sync selection, first match wins:
  - halfline < BROAD_HL: tv_sync = ~(hpos < BROAD_CLKS).
  - halfline < EQ_POST_HL or halfline >= EQ_PRE_HL: tv_sync = ~(hpos < EQ_CLKS).
  - otherwise: tv_sync = ~(pos < HSYNC_CLKS).
- fieldzone = the first two cases. tv_blank = fieldzone | pos < BLANK_END | pos >= BLANK_START.
- tv_burst = ~fieldzone & BURST_START <= pos <= BURST_END.
- osd_vsync_n = ~(halfline == OSD_HL).
- ext resync:
  - ext_vs is sampled once per ce.
  - A falling edge with ext_lock = 1 forces pos = 0, halfline = 0, field_ctr + 1, field_start = 1, line_start = 1.
  - Resync takes priority over a simultaneous natural wrap; field_ctr increments only once.
  - With ext_lock = 0 the edge is ignored and the generator free-runs.
- interlace may change at any time; it takes effect at the next field wrap check (FL is evaluated combinationally).
  - If halfline already exceeds the new FL-1, it wraps at the next increment.
- Parameter sanity (elaboration-time check): HSYNC_CLKS < BURST_START <= BURST_END < BLANK_END < BLANK_START < LINE_CLKS; EQ_CLKS < HSYNC_CLKS; BROAD_CLKS < HALF; BROAD_HL < EQ_POST_HL < EQ_PRE_HL < FIELD_HL.
- Reset asserted mid-line returns all state to reset values asynchronously. The first ce after release is pos = 0 -> 1.

Test Plan:
- Free-run, defaults, interlace = 0, ce = 1 -> line_start every 1536 clocks; field_start every 624×768 = 479232 clocks; field_ctr 0 -> 1 after first field.
- Halfline 20 -> tv_sync low for pos 0..113, tv_burst high pos 139..212, tv_blank high for pos < 249 and >= 1497.
- Halflines 0..4 sync low hpos 0..654; halflines 5..9 and 618..623 sync low hpos 0..55; tv_burst = 0 and tv_blank = 1 throughout.
- interlace = 1 -> fields of 625 half-lines; second field's halfline 0 begins at pos = 768; osd_vsync_n low exactly 768 clocks per field.
- ext_lock = 1 with ext_vs falling at pos = 1000, halfline = 300 -> next state pos = 0, halfline = 0, field_ctr + 1, single field_start. Repeat with ext_lock = 0 -> no change.
- ce toggling 1-of-2 -> all timings double in clk24 cycles. field_alt_en = 1 -> phase_sel inverts between consecutive fields on the same halfline. rst_n pulse mid-field -> outputs return to reset values immediately.
